// File: rtl/alu_issue_scheduler.sv
// Dual-lane ALU issue scheduler: grants lane A/B requests in split or unified mode,
// holds the issued fields for ALU_LAT cycles and pulses per-lane completion.
module alu_issue_scheduler #(
    parameter int unsigned ALU_LAT = 2,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [6:0]       a_opcode,
    input  logic [2:0]       a_funct3,
    input  logic [6:0]       a_funct7,
    input  logic             a_wide,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [6:0]       b_opcode,
    input  logic [2:0]       b_funct3,
    input  logic [6:0]       b_funct7,
    input  logic             b_wide,
    output logic             mode,
    output logic [6:0]       opcodeA,
    output logic [6:0]       opcodeB,
    output logic [2:0]       funct3A,
    output logic [2:0]       funct3B,
    output logic [6:0]       funct7A,
    output logic [6:0]       funct7B,
    output logic             res_a_valid,
    output logic             res_b_valid,
    output logic             busy,
    output logic [CNT_W-1:0] issue_cnt
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [3:0] LAT_M1 = 4'(ALU_LAT - 1);

    state_t           state_q, state_d;
    logic [3:0]       left_q, left_d;
    logic             lane_a_q, lane_a_d;
    logic             lane_b_q, lane_b_d;
    logic             ptr_q, ptr_d;
    logic             mode_q, mode_d;
    logic [6:0]       opcode_a_q, opcode_a_d;
    logic [6:0]       opcode_b_q, opcode_b_d;
    logic [2:0]       funct3_a_q, funct3_a_d;
    logic [2:0]       funct3_b_q, funct3_b_d;
    logic [6:0]       funct7_a_q, funct7_a_d;
    logic [6:0]       funct7_b_q, funct7_b_d;
    logic             res_a_q, res_a_d;
    logic             res_b_q, res_b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             both, conflict, grant_a, grant_b, can_issue;
    logic             acc_a, acc_b, unified;
    logic [CNT_W:0]   cnt_sum;

    always_comb begin
        both      = a_valid && b_valid;
        conflict  = both && (a_wide || b_wide);
        if (conflict) begin
            grant_a = !ptr_q;
            grant_b = ptr_q;
        end else begin
            grant_a = a_valid;
            grant_b = b_valid;
        end
        can_issue = (state_q == IDLE) && !flush && !rst;
        a_ready   = can_issue && grant_a;
        b_ready   = can_issue && grant_b;
        acc_a     = a_valid && a_ready;
        acc_b     = b_valid && b_ready;
        unified   = (acc_a ^ acc_b) && (acc_a ? a_wide : b_wide);
        cnt_sum   = {1'b0, cnt_q} + (CNT_W+1)'(acc_a) + (CNT_W+1)'(acc_b);
    end

    always_comb begin
        state_d    = state_q;
        left_d     = left_q;
        lane_a_d   = lane_a_q;
        lane_b_d   = lane_b_q;
        ptr_d      = ptr_q;
        mode_d     = mode_q;
        opcode_a_d = opcode_a_q;
        opcode_b_d = opcode_b_q;
        funct3_a_d = funct3_a_q;
        funct3_b_d = funct3_b_q;
        funct7_a_d = funct7_a_q;
        funct7_b_d = funct7_b_q;
        res_a_d    = 1'b0;
        res_b_d    = 1'b0;
        cnt_d      = cnt_q;
        case (state_q)
            IDLE: begin
                if (acc_a || acc_b) begin
                    state_d    = BUSY;
                    left_d     = LAT_M1;
                    lane_a_d   = acc_a;
                    lane_b_d   = acc_b;
                    ptr_d      = conflict ? !ptr_q : ptr_q;
                    cnt_d      = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
                    mode_d     = unified;
                    opcode_a_d = '0;
                    opcode_b_d = '0;
                    funct3_a_d = '0;
                    funct3_b_d = '0;
                    funct7_a_d = '0;
                    funct7_b_d = '0;
                    // A unified op from lane B is steered onto the A ports.
                    if (unified && acc_b) begin
                        opcode_a_d = b_opcode;
                        funct3_a_d = b_funct3;
                        funct7_a_d = b_funct7;
                    end else begin
                        if (acc_a) begin
                            opcode_a_d = a_opcode;
                            funct3_a_d = a_funct3;
                            funct7_a_d = a_funct7;
                        end
                        if (acc_b) begin
                            opcode_b_d = b_opcode;
                            funct3_b_d = b_funct3;
                            funct7_b_d = b_funct7;
                        end
                    end
                    res_a_d = acc_a && (LAT_M1 == 4'd0);
                    res_b_d = acc_b && (LAT_M1 == 4'd0);
                end
            end
            BUSY: begin
                if (flush || left_q == 4'd0) begin
                    state_d    = IDLE;
                    left_d     = '0;
                    lane_a_d   = 1'b0;
                    lane_b_d   = 1'b0;
                    mode_d     = 1'b1;
                    opcode_a_d = '0;
                    opcode_b_d = '0;
                    funct3_a_d = '0;
                    funct3_b_d = '0;
                    funct7_a_d = '0;
                    funct7_b_d = '0;
                end else begin
                    left_d  = left_q - 4'd1;
                    res_a_d = lane_a_q && (left_q == 4'd1);
                    res_b_d = lane_b_q && (left_q == 4'd1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            left_q     <= '0;
            lane_a_q   <= 1'b0;
            lane_b_q   <= 1'b0;
            ptr_q      <= 1'b0;
            mode_q     <= 1'b1;
            opcode_a_q <= '0;
            opcode_b_q <= '0;
            funct3_a_q <= '0;
            funct3_b_q <= '0;
            funct7_a_q <= '0;
            funct7_b_q <= '0;
            res_a_q    <= 1'b0;
            res_b_q    <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            left_q     <= left_d;
            lane_a_q   <= lane_a_d;
            lane_b_q   <= lane_b_d;
            ptr_q      <= ptr_d;
            mode_q     <= mode_d;
            opcode_a_q <= opcode_a_d;
            opcode_b_q <= opcode_b_d;
            funct3_a_q <= funct3_a_d;
            funct3_b_q <= funct3_b_d;
            funct7_a_q <= funct7_a_d;
            funct7_b_q <= funct7_b_d;
            res_a_q    <= res_a_d;
            res_b_q    <= res_b_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        mode        = mode_q;
        opcodeA     = opcode_a_q;
        opcodeB     = opcode_b_q;
        funct3A     = funct3_a_q;
        funct3B     = funct3_b_q;
        funct7A     = funct7_a_q;
        funct7B     = funct7_b_q;
        res_a_valid = res_a_q;
        res_b_valid = res_b_q;
        busy        = (state_q == BUSY);
        issue_cnt   = cnt_q;
    end

endmodule

// File: tb/tb_alu_issue_scheduler.sv
// Scoreboard bench for alu_issue_scheduler: a transaction-level model predicts grants,
// held fields and completion pulses; a negedge monitor compares against the DUT.
module tb_alu_issue_scheduler;

    localparam int ALU_LAT = 2;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, flush = 1'b0;
    logic a_valid = 1'b0, a_wide = 1'b0, b_valid = 1'b0, b_wide = 1'b0;
    logic [6:0] a_opcode = '0, a_funct7 = '0, b_opcode = '0, b_funct7 = '0;
    logic [2:0] a_funct3 = '0, b_funct3 = '0;
    logic a_ready, b_ready, mode, res_a_valid, res_b_valid, busy;
    logic [6:0] opcodeA, opcodeB, funct7A, funct7B;
    logic [2:0] funct3A, funct3B;
    logic [CNT_W-1:0] issue_cnt;

    alu_issue_scheduler #(.ALU_LAT(ALU_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_funct3(a_funct3),
        .a_funct7(a_funct7), .a_wide(a_wide),
        .b_valid(b_valid), .b_ready(b_ready), .b_opcode(b_opcode), .b_funct3(b_funct3),
        .b_funct7(b_funct7), .b_wide(b_wide),
        .mode(mode), .opcodeA(opcodeA), .opcodeB(opcodeB), .funct3A(funct3A),
        .funct3B(funct3B), .funct7A(funct7A), .funct7B(funct7B),
        .res_a_valid(res_a_valid), .res_b_valid(res_b_valid), .busy(busy),
        .issue_cnt(issue_cnt)
    );

    int n_checks = 0, n_fail = 0, cyc = 0;

    typedef struct {int due; logic [1:0] lanes;} res_t;
    res_t pend[$];

    int m_left = 0, m_cnt = 0;
    logic m_ptr = 1'b0, m_mode = 1'b1;
    logic [6:0] m_opA = '0, m_opB = '0, m_f7A = '0, m_f7B = '0;
    logic [2:0] m_f3A = '0, m_f3B = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [1:0] grant_of(input logic va, input logic vb,
                                            input logic wa, input logic wb, input logic p);
        if (va && vb) return (!wa && !wb) ? 2'b11 : (p ? 2'b10 : 2'b01);
        return {vb, va};
    endfunction

    task automatic model_idle();
        m_mode = 1'b1;
        m_opA = '0; m_opB = '0; m_f3A = '0; m_f3B = '0; m_f7A = '0; m_f7B = '0;
    endtask

    // Reference model: one issue window of ALU_LAT busy cycles per accept.
    always @(posedge clk) begin
        logic [1:0] g;
        if (rst) begin
            m_left = 0; m_ptr = 1'b0; m_cnt = 0;
            pend.delete();
            model_idle();
        end else if (m_left > 0) begin
            if (flush) begin
                m_left = 0;
                pend.delete();
            end else begin
                m_left--;
            end
            if (m_left == 0) model_idle();
        end else if (!flush) begin
            g = grant_of(a_valid, b_valid, a_wide, b_wide, m_ptr);
            if (g != 2'b00) begin
                if (a_valid && b_valid && (a_wide || b_wide)) m_ptr = !m_ptr;
                m_cnt = m_cnt + int'(g[0]) + int'(g[1]);
                if (m_cnt > CNT_MAX) m_cnt = CNT_MAX;
                m_left = ALU_LAT;
                model_idle();
                m_mode = 1'b0;
                if ((g == 2'b01 && a_wide) || (g == 2'b10 && b_wide)) begin
                    m_mode = 1'b1;
                    if (g[0]) begin m_opA = a_opcode; m_f3A = a_funct3; m_f7A = a_funct7; end
                    else      begin m_opA = b_opcode; m_f3A = b_funct3; m_f7A = b_funct7; end
                end else begin
                    if (g[0]) begin m_opA = a_opcode; m_f3A = a_funct3; m_f7A = a_funct7; end
                    if (g[1]) begin m_opB = b_opcode; m_f3B = b_funct3; m_f7B = b_funct7; end
                end
                pend.push_back('{cyc + ALU_LAT, g});
            end
        end
        cyc++;
    end

    // Monitor: pops the scoreboard when the DUT pulses a result, checks held state each cycle.
    always @(negedge clk) begin
        res_t h;
        logic [1:0] g;
        if (res_a_valid || res_b_valid) begin
            if (pend.size() == 0) begin
                check("res_unexpected", {30'd0, res_b_valid, res_a_valid}, 32'd0);
            end else begin
                h = pend.pop_front();
                check("res_lanes", {30'd0, res_b_valid, res_a_valid}, {30'd0, h.lanes});
                check("res_cycle", cyc, h.due);
            end
        end else if (pend.size() > 0 && pend[0].due <= cyc) begin
            h = pend.pop_front();
            check("res_missing", 32'd0, {30'd0, h.lanes});
        end
        g = grant_of(a_valid, b_valid, a_wide, b_wide, m_ptr);
        if (m_left != 0 || flush || rst) g = 2'b00;
        check("ready", {30'd0, b_ready, a_ready}, {30'd0, g});
        check("busy", busy, m_left > 0);
        check("mode", mode, m_mode);
        check("opcodeA", opcodeA, m_opA);
        check("opcodeB", opcodeB, m_opB);
        check("funct3A", funct3A, m_f3A);
        check("funct3B", funct3B, m_f3B);
        check("funct7A", funct7A, m_f7A);
        check("funct7B", funct7B, m_f7B);
        check("issue_cnt", issue_cnt, m_cnt);
    end

    task automatic tick();
        logic xa, xb;
        @(negedge clk);
        xa = a_valid && a_ready;
        xb = b_valid && b_ready;
        @(posedge clk);
        #1;
        if (xa) a_valid = 1'b0;
        if (xb) b_valid = 1'b0;
    endtask

    task automatic set_a(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7, input logic w);
        a_valid = 1'b1; a_opcode = op; a_funct3 = f3; a_funct7 = f7; a_wide = w;
    endtask

    task automatic set_b(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7, input logic w);
        b_valid = 1'b1; b_opcode = op; b_funct3 = f3; b_funct7 = f7; b_wide = w;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((a_valid || b_valid) && n < budget) begin
            tick();
            n++;
        end
        if (a_valid || b_valid) begin
            check("drain_timeout", {30'd0, b_valid, a_valid}, 32'd0);
            a_valid = 1'b0;
            b_valid = 1'b0;
        end
        repeat (ALU_LAT + 2) tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Both narrow: ADD on A, SUB on B, split issue.
        set_a(7'b0110011, 3'b000, 7'b0000000, 1'b0);
        set_b(7'b0110011, 3'b000, 7'b0100000, 1'b0);
        drain(20);

        // Only B valid, wide SRA: unified, fields on A ports.
        set_b(7'b0110011, 3'b101, 7'b0100000, 1'b1);
        drain(20);

        // Both wide and held: round-robin A, B, A.
        set_a(7'b0110011, 3'b001, 7'b0000000, 1'b1);
        set_b(7'b0010011, 3'b111, 7'b0000000, 1'b1);
        repeat (3 * (ALU_LAT + 1) + 1) begin
            tick();
            if (!a_valid) set_a(7'b0110011, 3'b001, 7'b0000000, 1'b1);
            if (!b_valid) set_b(7'b0010011, 3'b111, 7'b0000000, 1'b1);
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        drain(20);

        // Flush one cycle after an accept, then flush racing a valid in IDLE.
        set_a(7'b0110011, 3'b100, 7'b0000000, 1'b0);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        flush = 1'b1;
        set_a(7'b0110011, 3'b110, 7'b0000000, 1'b0);
        tick();
        flush = 1'b0;
        drain(20);

        // Counter saturation with a 4-bit counter.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (18) begin
            set_a(7'($urandom), 3'($urandom), 7'($urandom), 1'($urandom));
            drain(10);
        end

        // Reset in the middle of a busy window.
        set_b(7'b0110011, 3'b010, 7'b0000000, 1'b1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (3) tick();

        // Randomized traffic with occasional flush and reset.
        repeat (1500) begin
            if (!a_valid && ($urandom % 2 == 0))
                set_a(7'($urandom), 3'($urandom), 7'($urandom), 1'($urandom));
            if (!b_valid && ($urandom % 2 == 0))
                set_b(7'($urandom), 3'($urandom), 7'($urandom), 1'($urandom));
            flush = ($urandom % 12 == 0);
            rst   = ($urandom % 97 == 0);
            tick();
        end
        flush = 1'b0;
        rst = 1'b0;
        drain(50);
        check("pending_empty", pend.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
